// File: rtl/narrator_pkg.sv
// narrator_pkg: shared state encoding, word size and sample type for the narrator sequencer
package narrator_pkg;
  localparam int WORD_BYTES = 4;
  localparam int I_IDLE = 0, I_FETCH = 1, I_LOOKUP = 2, I_CHECK = 3, I_RD_REQ = 4;
  localparam int I_RD_WAIT = 5, I_EMIT_LO = 6, I_EMIT_HI = 7, I_ADV = 8, I_NEXT_PH = 9;
  typedef logic signed [15:0] sample_t;
  typedef enum logic [9:0] {
    IDLE    = 10'd1 << I_IDLE,
    FETCH   = 10'd1 << I_FETCH,
    LOOKUP  = 10'd1 << I_LOOKUP,
    CHECK   = 10'd1 << I_CHECK,
    RD_REQ  = 10'd1 << I_RD_REQ,
    RD_WAIT = 10'd1 << I_RD_WAIT,
    EMIT_LO = 10'd1 << I_EMIT_LO,
    EMIT_HI = 10'd1 << I_EMIT_HI,
    ADV     = 10'd1 << I_ADV,
    NEXT_PH = 10'd1 << I_NEXT_PH
  } state_t;
endpackage

// File: rtl/narrator_sequencer_if.sv
// narrator_sequencer_if: address table, flash read port and audio output of the sequencer
interface narrator_sequencer_if #(parameter int CODE_W = 6, parameter int ADDR_W = 24);
  import narrator_pkg::*;
  logic [CODE_W-1:0] tbl_index;
  logic [ADDR_W-1:0] tbl_start;
  logic [ADDR_W-1:0] tbl_end;
  logic              flash_read;
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_waitrequest;
  logic              flash_readdatavalid;
  logic [31:0]       flash_readdata;
  sample_t           audio_sample;
  logic              audio_valid;
  modport master (
    output tbl_index, flash_read, flash_addr, audio_sample, audio_valid,
    input  tbl_start, tbl_end, flash_waitrequest, flash_readdatavalid, flash_readdata
  );
  modport slave (
    input  tbl_index, flash_read, flash_addr, audio_sample, audio_valid,
    output tbl_start, tbl_end, flash_waitrequest, flash_readdatavalid, flash_readdata
  );
endinterface

// File: rtl/narrator_sequencer_sync_fifo.sv
// sync_fifo: phoneme code queue with simultaneous push/pop and single-cycle flush
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  // pointer and occupancy tracking; flush drops everything queued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage write
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
endmodule

// File: rtl/narrator_sequencer.sv
// narrator_sequencer: queues phoneme codes and streams their flash words as paced audio samples
module narrator_sequencer
  import narrator_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CODE_W = 6,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_wr,
  input  logic [CODE_W-1:0] code_in,
  input  logic              abort,
  input  logic              play_enable,
  input  logic              sample_tick,
  narrator_sequencer_if.master bus,
  output logic              phoneme_done,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow,
  output logic              bad_entry
);
  localparam int SH = $clog2(WORD_BYTES);
  localparam int WA = ADDR_W - SH;
  state_t state, nxt;
  logic [CODE_W-1:0] fifo_dout;
  logic [WA-1:0] waddr, wend;
  logic [31:0] word;
  logic empty, push, pop, kill, fire, last, bad, can_go, aborting;
  assign pop = state[I_FETCH];
  assign push = code_wr & ~abort & (~fifo_full | pop);
  assign kill = abort | aborting;
  assign fire = sample_tick & play_enable & ~abort;
  assign last = waddr == wend;
  assign bad = bus.tbl_start > bus.tbl_end;
  assign can_go = ~empty & play_enable;
  assign busy = ~empty | ~state[I_IDLE];
  assign bus.flash_read = state[I_RD_REQ];
  assign bus.flash_addr = {waddr, SH'(0)};
  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(CODE_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(abort),
    .din(code_in), .dout(fifo_dout), .full(fifo_full), .empty(empty)
  );
  // next state; abort forces IDLE except while a flash transaction must still finish
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = can_go ? FETCH : IDLE;
      FETCH:   nxt = LOOKUP;
      LOOKUP:  nxt = CHECK;
      CHECK:   nxt = bad ? NEXT_PH : RD_REQ;
      RD_REQ:  nxt = bus.flash_waitrequest ? RD_REQ : RD_WAIT;
      RD_WAIT: nxt = !bus.flash_readdatavalid ? RD_WAIT : kill ? IDLE : EMIT_LO;
      EMIT_LO: nxt = fire ? EMIT_HI : EMIT_LO;
      EMIT_HI: nxt = fire ? ADV : EMIT_HI;
      ADV:     nxt = last ? NEXT_PH : RD_REQ;
      NEXT_PH: nxt = can_go ? FETCH : IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && !(state[I_RD_REQ] || state[I_RD_WAIT])) nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // datapath: table lookup, word address walk, sample emission and sticky flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aborting <= 1'b0;
      bus.tbl_index <= '0;
      waddr <= '0;
      wend <= '0;
      word <= '0;
      bus.audio_sample <= '0;
      bus.audio_valid <= 1'b0;
      phoneme_done <= 1'b0;
      overflow <= 1'b0;
      bad_entry <= 1'b0;
    end else begin
      aborting <= kill & (nxt[I_RD_REQ] | nxt[I_RD_WAIT]);
      bus.tbl_index <= pop ? fifo_dout : bus.tbl_index;
      if (state[I_CHECK]) begin
        waddr <= bus.tbl_start[ADDR_W-1:SH];
        wend <= bus.tbl_end[ADDR_W-1:SH];
      end else if (state[I_ADV] && !last) waddr <= waddr + WA'(1);
      if (state[I_RD_WAIT] && bus.flash_readdatavalid) word <= bus.flash_readdata;
      bus.audio_valid <= fire & (state[I_EMIT_LO] | state[I_EMIT_HI]);
      if (fire && state[I_EMIT_LO]) bus.audio_sample <= word[15:0];
      else if (fire && state[I_EMIT_HI]) bus.audio_sample <= word[31:16];
      phoneme_done <= ~abort & ((state[I_CHECK] & bad) | (state[I_ADV] & last));
      overflow <= ~abort & (overflow | (code_wr & fifo_full & ~pop));
      bad_entry <= ~abort & (bad_entry | (state[I_CHECK] & bad));
    end
endmodule

// File: tb/tb_narrator_sequencer.sv
// tb_narrator_sequencer: scoreboard bench with table, flash and tick models around narrator_sequencer
module tb_narrator_sequencer;
  import narrator_pkg::*;
  logic clk = 0, rst_n = 0, code_wr = 0, abort = 0, play_enable = 0, sample_tick = 0;
  logic [5:0] code_in = '0;
  logic phoneme_done, busy, fifo_full, overflow, bad_entry;
  narrator_sequencer_if #(.CODE_W(6), .ADDR_W(24)) bus();
  narrator_sequencer #(.FIFO_DEPTH(8), .CODE_W(6), .ADDR_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .code_wr(code_wr), .code_in(code_in), .abort(abort),
    .play_enable(play_enable), .sample_tick(sample_tick), .bus(bus),
    .phoneme_done(phoneme_done), .busy(busy), .fifo_full(fifo_full),
    .overflow(overflow), .bad_entry(bad_entry)
  );
  always #5 clk = ~clk;
  int nchk = 0, nfail = 0, ndone = 0, nsamp = 0, wait_n = 0, lat = 1;
  int tc = 0, wcnt = 0, pcnt = 0;
  logic [23:0] paddr, hold;
  logic [23:0] exp_addr[$];
  logic [15:0] exp_smp[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] fword(input logic [23:0] a);
    return {4'hB, a[11:0], 4'hA, a[11:0]};
  endfunction
  function automatic logic [47:0] tentry(input logic [5:0] c);
    case (c)
      6'd1: return {24'h000000, 24'h000004};
      6'd2: return {24'h000010, 24'h000010};
      6'd3: return {24'h000100, 24'h000108};
      6'd4: return {24'h000200, 24'h0001FC};
      6'd5: return {24'h000300, 24'h000300};
      6'd6: return {24'h000400, 24'h00040C};
      default: return {24'h000F00, 24'h000F00};
    endcase
  endfunction
  // synchronous address table: one cycle after tbl_index
  always @(posedge clk) {bus.tbl_start, bus.tbl_end} <= tentry(bus.tbl_index);
  // audio tick every 10 cycles
  always @(posedge clk) begin
    tc <= (tc == 9) ? 0 : tc + 1;
    sample_tick <= (tc == 9);
  end
  // flash slave: wait_n waitrequest cycles per read, data lat cycles after acceptance
  assign bus.flash_waitrequest = bus.flash_read && (wcnt < wait_n);
  always @(posedge clk) begin
    bus.flash_readdatavalid <= (pcnt == 1);
    if (pcnt == 1) bus.flash_readdata <= fword(paddr);
    if (pcnt != 0) pcnt <= pcnt - 1;
    if (bus.flash_read) begin
      if (wcnt == 0) hold <= bus.flash_addr;
      if (wcnt < wait_n) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        paddr <= bus.flash_addr;
        pcnt <= lat;
      end
    end
  end
  // monitor: compares emitted samples and accepted read addresses against the scoreboard
  always @(negedge clk) if (rst_n) begin
    if (phoneme_done) ndone++;
    if (bus.audio_valid) begin
      nsamp++;
      if (exp_smp.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_sample: got %h expected none", bus.audio_sample);
      end else chk("sample", {16'h0, bus.audio_sample}, {16'h0, exp_smp.pop_front()});
    end
    if (bus.flash_read && !bus.flash_waitrequest) begin
      if (exp_addr.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_read: got %h expected none", bus.flash_addr);
      end else chk("read_addr", {8'h0, bus.flash_addr}, {8'h0, exp_addr.pop_front()});
    end
    if (bus.flash_read && bus.flash_waitrequest && wcnt > 0)
      chk("addr_stable", {8'h0, bus.flash_addr}, {8'h0, hold});
  end
  task automatic expect_word(input logic [23:0] a);
    exp_addr.push_back(a);
    exp_smp.push_back({4'hA, a[11:0]});
    exp_smp.push_back({4'hB, a[11:0]});
  endtask
  task automatic push(input logic [5:0] c);
    @(negedge clk);
    code_wr = 1;
    code_in = c;
  endtask
  task automatic end_push;
    @(negedge clk);
    code_wr = 0;
  endtask
  task automatic pulse_abort;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask
  task automatic wait_idle(input string nm);
    for (int n = 0; n < 3000 && busy; n++) @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
  endtask
  task automatic check_empty(input string nm);
    chk({nm, "_samples_left"}, exp_smp.size(), 0);
    chk({nm, "_reads_left"}, exp_addr.size(), 0);
  endtask
  initial begin
    int d0, s0, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_read", bus.flash_read, 0);
    chk("rst_addr", bus.flash_addr, 0);
    chk("rst_valid", bus.audio_valid, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_full", fifo_full, 0);
    chk("idle_ovf", overflow, 0);
    chk("idle_bad", bad_entry, 0);
    chk("idle_done", phoneme_done, 0);
    chk("idle_index", bus.tbl_index, 0);
    play_enable = 1;
    // single phoneme, three words, first-read latency
    d0 = ndone;
    expect_word(24'h100); expect_word(24'h104); expect_word(24'h108);
    push(6'd3);
    end_push;
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      if (bus.flash_read) break;
    end
    chk("first_read_latency", n, 4);
    wait_idle("t1");
    chk("t1_done", ndone - d0, 1);
    check_empty("t1");
    // three phonemes back to back with slow flash
    wait_n = 5;
    d0 = ndone;
    expect_word(24'h000); expect_word(24'h004); expect_word(24'h010);
    expect_word(24'h100); expect_word(24'h104); expect_word(24'h108);
    push(6'd1); push(6'd2); push(6'd3);
    end_push;
    wait_idle("t2");
    chk("t2_done", ndone - d0, 3);
    check_empty("t2");
    wait_n = 0;
    // overflow: 9 pushes while paused, only the first 8 play
    play_enable = 0;
    for (int i = 0; i < 8; i++) push(6'd5);
    end_push;
    chk("t3_full", fifo_full, 1);
    chk("t3_ovf_before", overflow, 0);
    push(6'd6);
    end_push;
    chk("t3_ovf", overflow, 1);
    chk("t3_full_after", fifo_full, 1);
    for (int i = 0; i < 8; i++) expect_word(24'h300);
    d0 = ndone;
    play_enable = 1;
    wait_idle("t3");
    chk("t3_done", ndone - d0, 8);
    chk("t3_ovf_sticky", overflow, 1);
    check_empty("t3");
    pulse_abort;
    chk("t3_ovf_cleared", overflow, 0);
    // bad table entry skipped, next code plays
    d0 = ndone;
    expect_word(24'h300);
    push(6'd4); push(6'd5);
    end_push;
    wait_idle("t4");
    chk("t4_done", ndone - d0, 2);
    chk("t4_bad", bad_entry, 1);
    check_empty("t4");
    // abort while waiting for read data; the code pushed with abort is dropped
    lat = 3;
    d0 = ndone;
    exp_addr.push_back(24'h100);
    push(6'd3);
    end_push;
    for (n = 0; n < 50 && !(bus.flash_read && !bus.flash_waitrequest); n++) @(negedge clk);
    chk("t5_accept_seen", n < 50, 1);
    @(negedge clk);
    abort = 1;
    code_wr = 1;
    code_in = 6'd5;
    @(negedge clk);
    abort = 0;
    code_wr = 0;
    chk("t5_bad_cleared", bad_entry, 0);
    chk("t5_draining", busy, 1);
    chk("t5_full", fifo_full, 0);
    wait_idle("t5");
    repeat (30) @(negedge clk);
    chk("t5_still_idle", busy, 0);
    chk("t5_done", ndone - d0, 0);
    check_empty("t5");
    lat = 1;
    // pause mid-phoneme for 50 ticks, then resume at the same sample
    d0 = ndone;
    s0 = nsamp;
    expect_word(24'h400); expect_word(24'h404); expect_word(24'h408); expect_word(24'h40C);
    push(6'd6);
    end_push;
    for (n = 0; n < 500 && nsamp < s0 + 3; n++) @(negedge clk);
    chk("t6_three_samples", nsamp - s0, 3);
    play_enable = 0;
    s0 = nsamp;
    repeat (500) @(negedge clk);
    chk("t6_pause_silent", nsamp - s0, 0);
    play_enable = 1;
    wait_idle("t6");
    chk("t6_done", ndone - d0, 1);
    check_empty("t6");
    // reset in the middle of a read
    exp_addr.push_back(24'h400);
    push(6'd6);
    end_push;
    for (n = 0; n < 50 && !bus.flash_read; n++) @(negedge clk);
    chk("t7_read_seen", bus.flash_read, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_read", bus.flash_read, 0);
    chk("t7_busy", busy, 0);
    chk("t7_addr", bus.flash_addr, 0);
    chk("t7_index", bus.tbl_index, 0);
    chk("t7_valid", bus.audio_valid, 0);
    exp_addr.delete();
    exp_smp.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("t7_after_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
